icache_fetch: RTL and testbench
===============================

Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction interface (inst_ren/inst_addr/inst_data) and the slow instruction ROM/memory bus.
- Generates rom_stall toward the core while a line refill is in progress.
- Refills one line word-serially over a req/ready handshake.
- Supports a whole-cache flush for self-modifying code and boot.

Parameters:
LINE_WORDS, 4, 32-bit words per line; power of two, at least 2
LINES, 64, number of cache lines; power of two, at least 2

Ports:
clk  input  1  main clock
rst_n  input  1  reset, asynchronous, active-low
inst_ren  input  1  core instruction read enable
inst_addr  input  32  core instruction byte address; bits [1:0] ignored
inst_data  output  32  instruction word returned to the core
rom_stall  output  1  high while the core must hold its fetch
flush  input  1  single-cycle pulse; invalidates all lines
mem_req  output  1  refill request to the memory bus, registered
mem_addr  output  32  word-aligned address of the current refill beat, registered
mem_ready  input  1  beat accepted; mem_data valid this cycle
mem_data  input  32  refill data word

Behaviour:
Address split
- WB = log2(LINE_WORDS), IB = log2(LINES).
- word = inst_addr[WB+1:2]; index = inst_addr[WB+IB+1:WB+2]; tag = inst_addr[31:WB+IB+2].

Storage
- data array: LINES x LINE_WORDS x 32 bits.
- tag array: LINES x tag width.
- valid bit per line.

Hit and miss
- hit = inst_ren & valid[index] & (tag_arr[index] == tag), evaluated combinationally.
- On a hit in IDLE: inst_data = data[index][word] in the same cycle; rom_stall = 0.
- rom_stall = inst_ren & ~hit, combinationally. It is therefore also high throughout REFILL whenever inst_ren is high.
- When rom_stall = 1 or inst_ren = 0, inst_data = 32'h0.

FSM, two states: IDLE, REFILL
- IDLE -> REFILL on a miss (inst_ren & ~hit & ~flush).
  - Latch miss_tag and miss_index.
  - Clear the beat counter.
  - Set mem_req = 1 and mem_addr = {miss_tag, miss_index, WB'b0, 2'b00} on the next edge.
- In REFILL, on each cycle with mem_ready = 1:
  - Write mem_data into data[miss_index][beat].
  - Increment beat and set mem_addr to the next word.
  - No write occurs without mem_ready; mem_req stays high.
- On the final beat (beat == LINE_WORDS-1 with mem_ready):
  - Write tag_arr[miss_index] = miss_tag.
  - Set valid[miss_index] = 1, unless an abort is pending.
  - mem_req = 0 next cycle; state returns to IDLE.
- Miss penalty with mem_ready tied high: LINE_WORDS+1 stall cycles. The lookup hits on the cycle after the return to IDLE.
- The refill always targets the latched line. Changes to inst_addr during REFILL do not alter it. The core holds inst_addr while stalled.

Flush
- Clears all valid bits in one cycle. Flush takes priority over a miss in the same cycle: no refill starts and rom_stall still follows the hit equation.
- Flush during REFILL sets abort. The refill runs to completion on the bus, but valid is not set. abort clears on the return to IDLE.

Reset (rst_n low, asynchronous)
- state = IDLE, all valid = 0, beat = 0, abort = 0, mem_req = 0, mem_addr = 0.
- Tag and data arrays are not reset.
- Reset mid-refill abandons the transfer immediately.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE cycle with hit.
  - miss_cnt increments on each IDLE->REFILL transition.
  - Both wrap at 2^32 and reset to 0 on rst_n.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then inst_ren=1, inst_addr=0x0000_0040 -> rom_stall=1; mem_req rises next cycle with mem_addr=0x40, 0x44, 0x48, 0x4C on successive ready beats; after 5 stall cycles (ready tied high) rom_stall=0 and inst_data equals the word returned at 0x40.
2. After test 1, fetch 0x4C -> rom_stall=0 in the same cycle, inst_data is the fourth refill word, mem_req stays 0.
3. Conflict: fetch 0x0000_0040, then 0x0000_1040 (same index 4, different tag) -> second fetch misses and refills; refetching 0x40 misses again.
4. mem_ready toggling 1,0,0,1,1,0,1 during a refill -> exactly 4 array writes, mem_addr advances only on ready cycles, rom_stall releases one cycle after the 4th ready.
5. flush pulse mid-refill of 0x80 -> refill completes (mem_req drops after 4 beats), the next fetch of 0x80 misses again; flush in IDLE makes a previously hit line miss.
6. Assert rst_n=0 asynchronously between edges mid-refill -> mem_req=0 and rom_stall=1 for an active fetch immediately; no line is valid after release. With ICACHE_STATS_EN defined, the counters read 0.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with word-serial line refill and whole-cache flush.
// Optional hit/miss counters are compiled in when ICACHE_STATS_EN is defined.
module icache_fetch #(
  parameter int LINE_WORDS = 4,
  parameter int LINES      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_ren,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_data,
  output logic        rom_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - WB - IB - 2;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_nxt;

  logic [LINE_WORDS-1:0][31:0] data_arr [LINES];
  logic [TW-1:0]               tag_arr  [LINES];
  logic [LINES-1:0]            valid;

  logic [WB-1:0] word;
  logic [IB-1:0] index;
  logic [TW-1:0] tag;
  logic [TW-1:0] miss_tag;
  logic [IB-1:0] miss_index;
  logic [WB-1:0] beat;
  logic          abort;
  logic          hit, miss, beat_ok, beat_last, fill_done;
  logic          unused_addr_lsb;

  assign word  = inst_addr[WB+1:2];
  assign index = inst_addr[WB+IB+1:WB+2];
  assign tag   = inst_addr[31:WB+IB+2];
  assign unused_addr_lsb = ^inst_addr[1:0];

  // Lookups only answer in IDLE, so the core stays stalled for the whole refill.
  assign hit       = inst_ren & (state == IDLE) & valid[index] & (tag_arr[index] == tag);
  assign miss      = (state == IDLE) & inst_ren & ~hit & ~flush;
  assign beat_ok   = (state == REFILL) & mem_ready;
  assign beat_last = (beat == WB'(LINE_WORDS-1));
  assign fill_done = beat_ok & beat_last;

  assign rom_stall = inst_ren & ~hit;
  assign inst_data = hit ? data_arr[index][word] : 32'h0;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss) state_nxt = REFILL;
      REFILL:  if (fill_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid      <= '0;
      beat       <= '0;
      abort      <= 1'b0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      miss_tag   <= '0;
      miss_index <= '0;
    end else begin
      state <= state_nxt;
      if (miss) begin
        miss_tag   <= tag;
        miss_index <= index;
        beat       <= '0;
        mem_req    <= 1'b1;
        mem_addr   <= {inst_addr[31:WB+2], {(WB+2){1'b0}}};
      end else if (beat_ok) begin
        beat     <= beat + 1'b1;
        mem_addr <= mem_addr + 32'd4;
        if (beat_last) mem_req <= 1'b0;
      end
      abort <= fill_done ? 1'b0 : (abort | (flush & (state == REFILL)));
      // A flush on the final beat itself must also keep the line invalid.
      if (flush)                  valid             <= '0;
      else if (fill_done && !abort) valid[miss_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_ok) begin
      data_arr[miss_index][beat] <= mem_data;
      if (beat_last) tag_arr[miss_index] <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 32'h0;
      miss_cnt <= 32'h0;
    end else begin
      if (hit)  hit_cnt  <= hit_cnt + 32'd1;
      if (miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: refill address scoreboard, stall-cycle counts, flush/abort and async reset.
module tb_icache_fetch;
  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        rom_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int beats    = 0;
  int b0;
  logic [31:0] gen = 32'd0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  bit          rdy_q[$];

  icache_fetch #(.LINE_WORDS(LW), .LINES(64)) dut (
    .clk(clk), .rst_n(rst_n), .inst_ren(inst_ren), .inst_addr(inst_addr),
    .inst_data(inst_data), .rom_stall(rom_stall), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mword(input logic [31:0] a, input logic [31:0] g);
    return (a * 32'h9E37_79B1) ^ (g << 24) ^ 32'h1357_9BDF;
  endfunction

  // Memory model: data is a fixed function of the beat address and the current generation.
  assign mem_data = mword(mem_addr, gen);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic f);
    @(posedge clk); #1;
    flush = f;
    if (mem_req && rdy_q.size() > 0) mem_ready = rdy_q.pop_front();
    else                             mem_ready = 1'b1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic fetch(input string tag, input logic [31:0] a, input int exp_stall,
                       input int refills, input int flush_at);
    int n = 0;
    inst_ren  = 1'b1;
    inst_addr = a;
    for (int r = 0; r < refills; r++)
      for (int k = 0; k < LW; k++)
        exp_addr_q.push_back({a[31:4], 4'h0} + 32'(4 * k));
    exp_data_q.push_back(mword({a[31:2], 2'b00}, gen));
    @(negedge clk);
    if (exp_stall > 0) chk({tag, "_stall_data"}, inst_data, 32'h0);
    while (rom_stall && n < 60) begin
      n++;
      step(n == flush_at);
      @(negedge clk);
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    chk({tag, "_data"}, inst_data, exp_data_q.pop_front());
    step(1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_req && mem_ready) begin
      beats++;
      if (exp_addr_q.size() == 0) chk("beat_unexpected", mem_addr, 32'hxxxx_xxxx);
      else                        chk("beat_addr", mem_addr, exp_addr_q.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; inst_ren = 1'b0; inst_addr = 32'h0; flush = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_addr",  mem_addr,       32'h0);
    chk("rst_rom_stall", 32'(rom_stall), 32'd0);
    chk("rst_inst_data", inst_data,      32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Cold miss, 5 stall cycles with ready tied high
    fetch("t1", 32'h0000_0040, 5, 1, -1);
    @(negedge clk); chk("t1_req_low", 32'(mem_req), 32'd0);
    step(1'b0);

    // Hit on the last word of the same line
    fetch("t2", 32'h0000_004C, 0, 0, -1);
    @(negedge clk); chk("t2_req_low", 32'(mem_req), 32'd0);
    step(1'b0);

    // Same index, different tag evicts and refills both ways
    gen = 32'd1;
    fetch("t3_conflict", 32'h0000_1040, 5, 1, -1);
    fetch("t3_refetch",  32'h0000_0040, 5, 1, -1);

    // Ready stutter: exactly four beats, release one cycle after the last
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    b0 = beats;
    fetch("t4", 32'h0000_0100, 8, 1, -1);
    chk("t4_beats", 32'(beats - b0), 32'd4);
    fetch("t4_word3", 32'h0000_010C, 0, 0, -1);

    // Flush mid-refill: refill completes, line stays invalid, held fetch refills again
    gen = 32'd2;
    b0 = beats;
    fetch("t5_abort", 32'h0000_0080, 10, 2, 2);
    chk("t5_beats", 32'(beats - b0), 32'd8);
    inst_ren = 1'b0; flush = 1'b1;
    step(1'b0);
    fetch("t5_idle_flush", 32'h0000_0080, 5, 1, -1);
    inst_addr = 32'h0000_0200; inst_ren = 1'b1; flush = 1'b1;
    @(negedge clk); chk("t5_flush_miss_stall", 32'(rom_stall), 32'd1);
    step(1'b0);
    inst_ren = 1'b0;
    @(negedge clk); chk("t5_flush_miss_no_req", 32'(mem_req), 32'd0);
    step(1'b0);

    // Async reset between edges in the middle of a refill
    inst_addr = 32'h0000_0300; inst_ren = 1'b1;
    for (int k = 0; k < LW; k++) exp_addr_q.push_back(32'h0000_0300 + 32'(4 * k));
    step(1'b0);
    step(1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_mem_req",   32'(mem_req),   32'd0);
    chk("t6_rom_stall", 32'(rom_stall), 32'd1);
    chk("t6_mem_addr",  mem_addr,       32'h0);
`ifdef ICACHE_STATS_EN
    chk("t6_hit_cnt",  hit_cnt,  32'h0);
    chk("t6_miss_cnt", miss_cnt, 32'h0);
`endif
    exp_addr_q.delete();
    inst_ren = 1'b0;
    step(1'b0);
    step(1'b0);
    rst_n = 1'b1;
    fetch("t6_after_rst", 32'h0000_0040, 5, 1, -1);

    chk("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
